// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : handshaked load/store responder over an internal RAM
//                      with a fixed number of wait states per access.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] done_count
);

  localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [3:0]          wcnt_q,      wcnt_d;
  logic                write_q,     write_d;
  logic [31:0]         addr_q,      addr_d;
  logic [31:0]         wdata_q,     wdata_d;
  logic [3:0]          wstrb_q,     wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rdata_q,     rdata_d;
  logic                err_q,       err_d;
  logic [31:0]         done_q,      done_d;

  logic [31:0]         mem_q [DEPTH_WORDS];

  logic                w_accept;
  logic                w_do_access;
  logic                w_acc_write;
  logic [31:0]         w_acc_addr;
  logic [31:0]         w_acc_wdata;
  logic [3:0]          w_acc_wstrb;
  logic [31:0]         w_off;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_acc_err;

  assign req_ready  = (state_q == IDLE);
  assign w_accept   = req_valid && req_ready;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign done_count = done_q;

  // With zero wait states the access happens on the accept edge itself,
  // so the operands come straight from the request port in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      w_acc_write = req_write;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
      w_acc_wstrb = req_wstrb;
    end else begin
      w_acc_write = write_q;
      w_acc_addr  = addr_q;
      w_acc_wdata = wdata_q;
      w_acc_wstrb = wstrb_q;
    end
  end

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fault.
  assign w_off     = w_acc_addr - BASE_ADDR;
  assign w_idx     = w_off[c_IDX_W+1:2];
  assign w_acc_err = (w_off[1:0] != 2'b00) || ((w_off >> (c_IDX_W + 2)) != 32'd0);

  assign w_do_access = reset &&
                       (((state_q == IDLE) && w_accept && (c_WS == 4'd0)) ||
                        ((state_q == WAIT) && (wcnt_q == 4'd1)));

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (c_WS == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wcnt_d  = c_WS;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          done_d      = done_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_do_access) begin
      rsp_valid_d = 1'b1;
      err_d       = w_acc_err;
      rdata_d     = (w_acc_err || w_acc_write) ? 32'd0 : mem_q[w_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      done_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // RAM contents survive reset; only the enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_write && !w_acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_wstrb[i]) begin
          mem_q[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : randomized self-checking bench for data_mem_responder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int          NDUT  = 2;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;
  localparam int          DEP0  = 1024;
  localparam int          DEP1  = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_write  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [3:0]  req_wstrb  [NDUT];
  logic        rsp_valid  [NDUT];
  logic        rsp_ready  [NDUT];
  logic [31:0] rsp_rdata  [NDUT];
  logic        rsp_err    [NDUT];
  logic [31:0] done_count [NDUT];

  data_mem_responder #(.DEPTH_WORDS(DEP0), .WAIT_STATES(WS0), .BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .done_count(done_count[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEP1), .WAIT_STATES(WS1), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .done_count(done_count[1])
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int acc_cyc [NDUT];
  bit rnd_ready  = 1'b0;

  // Transaction-level reference: one outstanding request per DUT, a RAM image,
  // and the cycle age of the outstanding request.
  logic [31:0] mm [NDUT][1024];
  bit          mk [NDUT][1024];
  bit          m_busy  [NDUT];
  int          m_age   [NDUT];
  bit          m_w     [NDUT];
  logic [31:0] m_a     [NDUT];
  logic [31:0] m_wd    [NDUT];
  logic [3:0]  m_st    [NDUT];
  logic [31:0] m_rdata [NDUT];
  bit          m_err   [NDUT];
  bit          m_rk    [NDUT];
  logic [31:0] m_cnt   [NDUT];

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (dut%0d) cycle %0d: got %08h, expected %08h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm, input int d);
    compared++;
    mismatched++;
    $display("FAIL %s (dut%0d) cycle %0d: wait bound expired", nm, d, cyc);
  endtask

  function automatic void model_reset(input int d);
    m_busy[d]  = 1'b0;
    m_age[d]   = 0;
    m_cnt[d]   = 32'd0;
    m_rdata[d] = 32'd0;
    m_err[d]   = 1'b0;
    m_rk[d]    = 1'b1;
  endfunction

  function automatic void commit(input int d);
    longint off;
    int     idx;
    off     = longint'(m_a[d]) - longint'(base_of(d));
    m_rk[d] = 1'b1;
    if ((m_a[d] % 4 != 0) || (off < 0) || (off >= longint'(dep_of(d)) * 4)) begin
      m_err[d]   = 1'b1;
      m_rdata[d] = 32'd0;
    end else begin
      idx      = int'(off / 4);
      m_err[d] = 1'b0;
      if (m_w[d]) begin
        for (int i = 0; i < 4; i++)
          if (m_st[d][i]) mm[d][idx][8*i +: 8] = m_wd[d][8*i +: 8];
        if (m_st[d] == 4'hF) mk[d][idx] = 1'b1;
        m_rdata[d] = 32'd0;
      end else begin
        m_rdata[d] = mm[d][idx];
        m_rk[d]    = mk[d][idx];
      end
    end
  endfunction

  function automatic void step(input int d);
    if (!reset) begin
      model_reset(d);
    end else if (m_busy[d]) begin
      if (m_age[d] >= ws_of(d)) begin
        if (rsp_ready[d]) begin
          m_busy[d] = 1'b0;
          m_cnt[d]  = m_cnt[d] + 32'd1;
        end
      end else begin
        m_age[d]++;
        if (m_age[d] == ws_of(d)) commit(d);
      end
    end else if (req_valid[d]) begin
      m_w[d]    = req_write[d];
      m_a[d]    = req_addr[d];
      m_wd[d]   = req_wdata[d];
      m_st[d]   = req_wstrb[d];
      m_busy[d] = 1'b1;
      m_age[d]  = 0;
      if (ws_of(d) == 0) commit(d);
    end
  endfunction

  initial begin : monitor
    bit exp_v;
    for (int d = 0; d < NDUT; d++) model_reset(d);
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (!reset) begin
          model_reset(d);
          chk("reset_rsp_rdata", d, rsp_rdata[d], 32'h0);
          chk("reset_rsp_err", d, 32'(rsp_err[d]), 32'h0);
        end
        exp_v = m_busy[d] && (m_age[d] >= ws_of(d));
        chk("req_ready", d, 32'(req_ready[d]), 32'(!m_busy[d]));
        chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(exp_v));
        if (exp_v) begin
          if (m_rk[d]) chk("rsp_rdata", d, rsp_rdata[d], m_rdata[d]);
          chk("rsp_err", d, 32'(rsp_err[d]), 32'(m_err[d]));
        end
        chk("done_count", d, done_count[d], m_cnt[d]);
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) step(d);
    end
  end

  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    int n;
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) note_timeout("accept", d);
    @(posedge clk);
    #1;
    acc_cyc[d]   = cyc;
    req_valid[d] = 1'($urandom_range(0, 1));
    req_write[d] = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_wstrb[d] = 4'($urandom);
  endtask

  task automatic wait_rsp(input int d, output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid[d] && rsp_ready[d]) break;
      lat++;
      if (lat > 200) begin
        note_timeout("response", d);
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) rsp_ready[d] = ($urandom_range(0, 3) != 0);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    lat++;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic er, output int lat);
    issue(d, w, a, wd, st);
    wait_rsp(d, rd, er, lat);
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int          r;
    logic [31:0] b;
    r = $urandom_range(0, 9);
    b = base_of(d);
    if (r < 7)       return b + 32'(4 * $urandom_range(0, 15));
    else if (r == 7) return b + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
    else if (r == 8) return b + 32'(dep_of(d) * 4) + 32'(4 * $urandom_range(0, 3));
    else             return b - 32'(4 * $urandom_range(1, 4));
  endfunction

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          prev_acc;
    logic [31:0] cnt_before;

    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_wstrb[d] = 4'd0;
      rsp_ready[d] = 1'b1;
      acc_cyc[d]   = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done_lit", 0, done_count[0], 32'd0);
    chk("reset_ready_lit", 0, 32'(req_ready[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Store then load, fixed three-edge accept-to-handshake latency.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("store_lat", 0, 32'(lat), 32'd3);
    chk("store_err", 0, 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("load_rdata", 0, rd, 32'hDEADBEEF);
    chk("load_err", 0, 32'(er), 32'd0);
    chk("load_lat", 0, 32'(lat), 32'd3);
    chk("done_after_two", 0, done_count[0], 32'd2);

    for (int k = 0; k < 16; k++) txn(0, 1'b1, 32'(4 * k), 32'h0, 4'hF, rd, er, lat);

    // Byte lanes.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("lanes_rdata", 0, rd, 32'h11BB33DD);

    // Faults.
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("misalign_err", 0, 32'(er), 32'd1);
    chk("misalign_rdata", 0, rd, 32'd0);
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
    chk("oob_err", 0, 32'(er), 32'd1);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("word0_intact", 0, rd, 32'd0);
    chk("word0_err", 0, 32'(er), 32'd0);

    // Backpressure with a second request waiting behind the held response.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h14;
    req_wstrb[0] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("bp_rdata", 0, rsp_rdata[0], 32'h11BB33DD);
      chk("bp_err", 0, 32'(rsp_err[0]), 32'd0);
      chk("bp_ready_low", 0, 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_after_hs", 0, 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_next_accepted", 0, 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;
    wait_rsp(0, rd, er, lat);
    chk("bp_next_rdata", 0, rd, 32'd0);

    // Reset while a store sits in its wait states.
    issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("abort_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("abort_done", 0, done_count[0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("aborted_store", 0, rd, 32'd0);

    // Randomized traffic on the two-wait-state instance.
    rnd_ready = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      txn(0, 1'($urandom_range(0, 1)), rand_addr(0), $urandom, 4'($urandom), rd, er, lat);
    end

    // Zero-wait-state instance: initialise, then back-to-back throughput.
    rnd_ready = 1'b0;
    for (int k = 0; k < 16; k++) txn(1, 1'b1, BASE1 + 32'(4 * k), 32'h0, 4'hF, rd, er, lat);
    prev_acc = 0;
    for (int k = 0; k < 8; k++) begin
      cnt_before = done_count[1];
      txn(1, 1'(k % 2), BASE1 + 32'(4 * k), 32'h01010101 * 32'(k), 4'hF, rd, er, lat);
      chk("b2b_lat", 1, 32'(lat), 32'd1);
      if (k > 0) chk("b2b_period", 1, 32'(acc_cyc[1] - prev_acc), 32'd2);
      prev_acc = acc_cyc[1];
      chk("b2b_done_inc", 1, done_count[1], cnt_before + 32'd1);
    end
    txn(1, 1'b0, BASE1 - 32'd4, 32'h0, 4'h0, rd, er, lat);
    chk("below_base_err", 1, 32'(er), 32'd1);
    txn(1, 1'b1, BASE1 + 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("end_of_ram_err", 1, 32'(er), 32'd1);
    txn(1, 1'b0, BASE1 + 32'h3C, 32'h0, 4'h0, rd, er, lat);
    chk("last_word_err", 1, 32'(er), 32'd0);
    chk("last_word_rdata", 1, rd, 32'd0);

    rnd_ready = 1'b1;
    repeat (80) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      txn(1, 1'($urandom_range(0, 1)), rand_addr(1), $urandom, 4'($urandom), rd, er, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
